// File: rtl/mips_ctrl_defs_pkg.sv
// rtl/mips_ctrl_defs_pkg.sv - shared encodings for the multicycle MIPS control unit
package mips_ctrl_defs;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    I_EXEC    = 4'd10,
    I_WB      = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  // ALUOp codes are also consumed by the ALU control decoder
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_OR    = 3'b011;
  localparam logic [2:0] ALUOP_AND   = 3'b100;
  localparam logic [2:0] ALUOP_SLT   = 3'b101;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_4      = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J,
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: is_legal_op = 1'b1;
      default:                           is_legal_op = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ANDI: imm_alu_op = ALUOP_AND;
      OP_ORI:  imm_alu_op = ALUOP_OR;
      OP_SLTI: imm_alu_op = ALUOP_SLT;
      default: imm_alu_op = ALUOP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// rtl/ctrl_output_decode.sv - maps (state, Op, mem_ready) onto datapath controls
module ctrl_output_decode
  import mips_ctrl_defs::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_4;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // IR and PC only latch once the fetch data is actually present
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: begin
        ctrl.alu_src_b  = SRCB_IMM_SH;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.illegal_op = !is_legal_op(op);
      end
      MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_RTYPE;
      end
      R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = imm_alu_op(op);
      end
      I_WB: begin
        ctrl.reg_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle MIPS main control: state register and retire counter
module multicycle_control_fsm
  import mips_ctrl_defs::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       Op,
  input  logic [5:0]       Func,
  input  logic             nop_instr,
  input  logic             mem_ready,
  input  logic             Zero,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             illegal_op,
  output logic [3:0]       state_dbg,
  output logic [CNT_W-1:0] instr_count
);

  state_t state;
  ctrl_t  ctrl_dec;
  ctrl_t  ctrl;

  // Func is resolved by the ALU control decoder and Zero by the PC write logic
  logic unused_inputs;
  assign unused_inputs = ^{Func, Zero};

  ctrl_output_decode u_decode (
    .state     (state),
    .op        (Op),
    .mem_ready (mem_ready),
    .ctrl      (ctrl_dec)
  );

  assign ctrl = rst ? '0 : ctrl_dec;

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign PCSource    = ctrl.pc_source;
  assign illegal_op  = ctrl.illegal_op;
  assign state_dbg   = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      instr_count <= '0;
    end else begin
      case (state)
        FETCH: if (mem_ready) state <= DECODE;
        DECODE: begin
          case (Op)
            OP_RTYPE: begin
              if (nop_instr) begin
                state       <= FETCH;
                instr_count <= instr_count + CNT_W'(1);
              end else begin
                state <= R_EXEC;
              end
            end
            OP_LW, OP_SW:                        state <= MEM_ADDR;
            OP_BEQ:                              state <= BRANCH;
            OP_J:                                state <= JUMP;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:   state <= I_EXEC;
            default:                             state <= FETCH;
          endcase
        end
        MEM_ADDR: state <= (Op == OP_SW) ? MEM_WRITE : MEM_READ;
        MEM_READ: if (mem_ready) state <= MEM_WB;
        MEM_WRITE: begin
          if (mem_ready) begin
            state       <= FETCH;
            instr_count <= instr_count + CNT_W'(1);
          end
        end
        R_EXEC: state <= R_WB;
        I_EXEC: state <= I_WB;
        MEM_WB, R_WB, BRANCH, JUMP, I_WB: begin
          state       <= FETCH;
          instr_count <= instr_count + CNT_W'(1);
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - table-driven check of the multicycle control FSM
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  Op, Func;
  logic        nop_instr, mem_ready, Zero;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0]  ALUSrcB, PCSource;
  logic [2:0]  ALUOp;
  logic [3:0]  state_dbg;
  logic [31:0] instr_count;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Func(Func), .nop_instr(nop_instr),
    .mem_ready(mem_ready), .Zero(Zero),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .illegal_op(illegal_op),
    .state_dbg(state_dbg), .instr_count(instr_count)
  );

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA}_ALUSrcB_ALUOp_PCSource_illegal
  logic [17:0] act;
  assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op};

  localparam logic [17:0] C_ZERO   = 18'b0000000000_00_000_00_0;
  localparam logic [17:0] C_FRDY   = 18'b1001010000_01_000_00_0;
  localparam logic [17:0] C_FWAIT  = 18'b0001000000_01_000_00_0;
  localparam logic [17:0] C_DEC    = 18'b0000000000_11_000_00_0;
  localparam logic [17:0] C_DECILL = 18'b0000000000_11_000_00_1;
  localparam logic [17:0] C_MADDR  = 18'b0000000001_10_000_00_0;
  localparam logic [17:0] C_MREAD  = 18'b0011000000_00_000_00_0;
  localparam logic [17:0] C_MWB    = 18'b0000001010_00_000_00_0;
  localparam logic [17:0] C_MWR    = 18'b0010100000_00_000_00_0;
  localparam logic [17:0] C_REXEC  = 18'b0000000001_00_010_00_0;
  localparam logic [17:0] C_RWB    = 18'b0000000110_00_000_00_0;
  localparam logic [17:0] C_BR     = 18'b0100000001_00_001_01_0;
  localparam logic [17:0] C_JMP    = 18'b1000000000_00_000_10_0;
  localparam logic [17:0] C_ORI    = 18'b0000000001_10_011_00_0;
  localparam logic [17:0] C_SLTI   = 18'b0000000001_10_101_00_0;
  localparam logic [17:0] C_IWB    = 18'b0000000010_00_000_00_0;

  typedef struct {
    logic [5:0]  op;
    logic        nop;
    logic        mr;
    logic        zero;
    logic [3:0]  st;
    logic [17:0] ctl;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ir_pulses;

  task automatic add(input logic [5:0] op, input logic nop, input logic mr, input logic zero,
                     input logic [3:0] st, input logic [17:0] ctl, input logic [31:0] cnt);
    vec_t v;
    v.op = op; v.nop = nop; v.mr = mr; v.zero = zero; v.st = st; v.ctl = ctl; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  initial begin
    // R-type add
    add(6'o00, 0, 1, 0, 4'd0,  C_FRDY,   0);
    add(6'o00, 0, 1, 0, 4'd1,  C_DEC,    0);
    add(6'o00, 0, 1, 0, 4'd6,  C_REXEC,  0);
    add(6'o00, 0, 1, 0, 4'd7,  C_RWB,    0);
    // lw with two fetch waits and one read wait (rows 4..11)
    add(6'b100011, 0, 0, 0, 4'd0, C_FWAIT, 1);
    add(6'b100011, 0, 0, 0, 4'd0, C_FWAIT, 1);
    add(6'b100011, 0, 1, 0, 4'd0, C_FRDY,  1);
    add(6'b100011, 0, 1, 0, 4'd1, C_DEC,   1);
    add(6'b100011, 0, 1, 0, 4'd2, C_MADDR, 1);
    add(6'b100011, 0, 0, 0, 4'd3, C_MREAD, 1);
    add(6'b100011, 0, 1, 0, 4'd3, C_MREAD, 1);
    add(6'b100011, 0, 1, 0, 4'd4, C_MWB,   1);
    // beq taken, then not taken
    add(6'b000100, 0, 1, 1, 4'd0, C_FRDY, 2);
    add(6'b000100, 0, 1, 1, 4'd1, C_DEC,  2);
    add(6'b000100, 0, 1, 1, 4'd8, C_BR,   2);
    add(6'b000100, 0, 1, 0, 4'd0, C_FRDY, 3);
    add(6'b000100, 0, 1, 0, 4'd1, C_DEC,  3);
    add(6'b000100, 0, 1, 0, 4'd8, C_BR,   3);
    // ori, slti
    add(6'b001101, 0, 1, 0, 4'd0,  C_FRDY, 4);
    add(6'b001101, 0, 1, 0, 4'd1,  C_DEC,  4);
    add(6'b001101, 0, 1, 0, 4'd10, C_ORI,  4);
    add(6'b001101, 0, 1, 0, 4'd11, C_IWB,  4);
    add(6'b001010, 0, 1, 0, 4'd0,  C_FRDY, 5);
    add(6'b001010, 0, 1, 0, 4'd1,  C_DEC,  5);
    add(6'b001010, 0, 1, 0, 4'd10, C_SLTI, 5);
    add(6'b001010, 0, 1, 0, 4'd11, C_IWB,  5);
    // illegal opcode, then NOP
    add(6'b111111, 0, 1, 0, 4'd0, C_FRDY,   6);
    add(6'b111111, 0, 1, 0, 4'd1, C_DECILL, 6);
    add(6'b000000, 1, 1, 0, 4'd0, C_FRDY,   6);
    add(6'b000000, 1, 1, 0, 4'd1, C_DEC,    6);
    // sw, j
    add(6'b101011, 0, 1, 0, 4'd0, C_FRDY,  7);
    add(6'b101011, 0, 1, 0, 4'd1, C_DEC,   7);
    add(6'b101011, 0, 1, 0, 4'd2, C_MADDR, 7);
    add(6'b101011, 0, 1, 0, 4'd5, C_MWR,   7);
    add(6'b000010, 0, 1, 0, 4'd0, C_FRDY,  8);
    add(6'b000010, 0, 1, 0, 4'd1, C_DEC,   8);
    add(6'b000010, 0, 1, 0, 4'd9, C_JMP,   8);
    // lw that will be aborted by reset in MEM_READ
    add(6'b100011, 0, 1, 0, 4'd0, C_FRDY,  9);
    add(6'b100011, 0, 1, 0, 4'd1, C_DEC,   9);
    add(6'b100011, 0, 1, 0, 4'd2, C_MADDR, 9);
    add(6'b100011, 0, 0, 0, 4'd3, C_MREAD, 9);

    rst = 1'b1; Op = '0; Func = 6'b100000; nop_instr = 1'b0; mem_ready = 1'b0; Zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_state", {28'd0, state_dbg}, 32'd0);
    check("reset_ctl", {14'd0, act}, {14'd0, C_ZERO});
    check("reset_count", instr_count, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    ir_pulses = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      Op = vecs[i].op; nop_instr = vecs[i].nop; mem_ready = vecs[i].mr; Zero = vecs[i].zero;
      @(negedge clk);
      check($sformatf("row%0d_state", i), {28'd0, state_dbg}, {28'd0, vecs[i].st});
      check($sformatf("row%0d_ctl", i), {14'd0, act}, {14'd0, vecs[i].ctl});
      check($sformatf("row%0d_count", i), instr_count, vecs[i].cnt);
      if (i >= 4 && i <= 11 && IRWrite) ir_pulses++;
      @(posedge clk);
      #1;
    end
    check("lw_irwrite_pulses", ir_pulses, 1);

    // reset mid-lw, still in MEM_READ
    rst = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    check("rst_hold_ctl_pre_edge", {14'd0, act}, {14'd0, C_ZERO});
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_state", {28'd0, state_dbg}, 32'd0);
    check("rst_ctl", {14'd0, act}, {14'd0, C_ZERO});
    check("rst_count", instr_count, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_state", {28'd0, state_dbg}, 32'd0);
    check("post_rst_ctl", {14'd0, act}, {14'd0, C_FWAIT});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
